// File: rtl/ft64_btb_mp.sv
// Direct-mapped branch target buffer: NRD registered lookups and an in-order update queue
// that drains one update per cycle into the table. Lookups see a same-edge drain write.
module ft64_btb_mp #(
  parameter int AMSB = 63,
  parameter int IDXW = 10,
  parameter int NRD  = 6,
  parameter int NWR  = 3,
  parameter int QLOG = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inv_all,
  input  logic [NWR-1:0]          upd_wr,
  input  logic [NWR*(AMSB+1)-1:0] upd_pc,
  input  logic [NWR*(AMSB+1)-1:0] upd_tgt,
  input  logic [NWR-1:0]          upd_tkn,
  output logic                    upd_rdy,
  input  logic [NRD*(AMSB+1)-1:0] lk_pc,
  input  logic [NRD*(AMSB+1)-1:0] lk_npc,
  output logic [NRD-1:0]          lk_hit,
  output logic [NRD*(AMSB+1)-1:0] lk_tgt,
  output logic [QLOG:0]           q_cnt
);
  localparam int W  = AMSB + 1;
  localparam int TW = W - IDXW - 2;
  localparam int NE = 1 << IDXW;
  localparam int QD = 1 << QLOG;

  logic [W-1:0]    qpc_q  [QD];
  logic [W-1:0]    qtgt_q [QD];
  logic [QD-1:0]   qtkn_q;
  logic [QLOG-1:0] head_q, tail_q;
  logic [QLOG:0]   cnt_q, cnt_d;

  logic [NE-1:0]   tbl_vld_q;
  logic [TW-1:0]   tbl_tag_q [NE];
  logic [W-1:0]    tbl_tgt_q [NE];

  logic [NRD-1:0]   lk_hit_q, lk_hit_d;
  logic [NRD*W-1:0] lk_tgt_q, lk_tgt_d;

  logic [QLOG-1:0] slot [NWR];
  logic [QLOG:0]   npush;
  logic            push_en, pop;
  logic [W-1:0]    hd_pc, hd_tgt;
  logic            hd_tkn;
  logic [IDXW-1:0] wr_idx;
  logic [TW-1:0]   wr_tag;
  logic            unused_hd_lo;

  assign upd_rdy = ({1'b0, cnt_q} + (QLOG+2)'(NWR)) <= (QLOG+2)'(QD);
  assign push_en = upd_rdy && !inv_all;
  assign pop     = (cnt_q != '0) && !inv_all;
  assign q_cnt   = cnt_q;
  assign lk_hit  = lk_hit_q;
  assign lk_tgt  = lk_tgt_q;

  assign hd_pc        = qpc_q[head_q];
  assign hd_tgt       = qtgt_q[head_q];
  assign hd_tkn       = qtkn_q[head_q];
  assign wr_idx       = hd_pc[IDXW+1:2];
  assign wr_tag       = hd_pc[W-1:IDXW+2];
  assign unused_hd_lo = ^hd_pc[1:0];

  // Strobed ports take consecutive slots from the tail so the queue never has gaps.
  always_comb begin
    npush = '0;
    for (int i = 0; i < NWR; i++) begin
      slot[i] = tail_q + npush[QLOG-1:0];
      if (upd_wr[i]) npush = npush + (QLOG+1)'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push_en) cnt_d = cnt_d + npush;
    if (pop)     cnt_d = cnt_d - (QLOG+1)'(1);
    if (inv_all) cnt_d = '0;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_lk
    logic [W-1:0]    pc;
    logic [IDXW-1:0] idx;
    logic            byp, hit;
    logic            unused_lo;

    assign pc        = lk_pc[p*W +: W];
    assign idx       = pc[IDXW+1:2];
    assign unused_lo = ^pc[1:0];
    assign byp       = pop && (wr_idx == idx);
    assign hit       = !inv_all && (byp ? (hd_tkn && (wr_tag == pc[W-1:IDXW+2]))
                                        : (tbl_vld_q[idx] && (tbl_tag_q[idx] == pc[W-1:IDXW+2])));
    assign lk_hit_d[p]        = hit;
    assign lk_tgt_d[p*W +: W] = !hit ? lk_npc[p*W +: W] : (byp ? hd_tgt : tbl_tgt_q[idx]);
  end

  // Queue payload and table tag/target are plain storage without reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < NWR; i++) begin
        if (upd_wr[i]) begin
          qpc_q[slot[i]]  <= upd_pc[i*W +: W];
          qtgt_q[slot[i]] <= upd_tgt[i*W +: W];
          qtkn_q[slot[i]] <= upd_tkn[i];
        end
      end
    end
    if (pop) begin
      tbl_tag_q[wr_idx] <= wr_tag;
      tbl_tgt_q[wr_idx] <= hd_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      tbl_vld_q <= '0;
      lk_hit_q  <= '0;
      lk_tgt_q  <= '0;
    end else begin
      if (inv_all) begin
        head_q    <= '0;
        tail_q    <= '0;
        tbl_vld_q <= '0;
      end else begin
        if (push_en) tail_q <= tail_q + npush[QLOG-1:0];
        if (pop) begin
          tbl_vld_q[wr_idx] <= hd_tkn;
          head_q            <= head_q + QLOG'(1);
        end
      end
      cnt_q    <= cnt_d;
      lk_hit_q <= lk_hit_d;
      lk_tgt_q <= lk_tgt_d;
    end
  end
endmodule

// File: tb/tb_ft64_btb_mp.sv
// Bench for ft64_btb_mp: directed scenarios plus random traffic against a queue/array model.
module tb_ft64_btb_mp;
  localparam int AMSB = 63;
  localparam int IDXW = 10;
  localparam int NRD  = 6;
  localparam int NWR  = 3;
  localparam int QLOG = 5;
  localparam int W    = AMSB + 1;
  localparam int NE   = 1 << IDXW;
  localparam int QD   = 1 << QLOG;

  logic             clk, rst_n, inv_all, upd_rdy;
  logic [NWR-1:0]   upd_wr, upd_tkn;
  logic [NWR*W-1:0] upd_pc, upd_tgt;
  logic [NRD*W-1:0] lk_pc, lk_npc, lk_tgt;
  logic [NRD-1:0]   lk_hit;
  logic [QLOG:0]    q_cnt;

  ft64_btb_mp #(.AMSB(AMSB), .IDXW(IDXW), .NRD(NRD), .NWR(NWR), .QLOG(QLOG)) dut (
    .clk(clk), .rst_n(rst_n), .inv_all(inv_all),
    .upd_wr(upd_wr), .upd_pc(upd_pc), .upd_tgt(upd_tgt), .upd_tkn(upd_tkn), .upd_rdy(upd_rdy),
    .lk_pc(lk_pc), .lk_npc(lk_npc), .lk_hit(lk_hit), .lk_tgt(lk_tgt), .q_cnt(q_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] pc; logic [W-1:0] tgt; bit tkn; } upd_t;
  upd_t         mq[$];
  bit           mvalid [NE];
  logic [W-1:0] mtag   [NE];
  logic [W-1:0] mtgt   [NE];
  bit           exp_hit [NRD];
  logic [W-1:0] exp_tgt [NRD];
  int           exp_cnt;
  logic [W-1:0] pool[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic int idx_of(logic [W-1:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic logic [W-1:0] rnd_pc();
    logic [W-1:0] pc;
    pc = (W'($urandom_range(0, 3)) << (IDXW + 2)) | (W'($urandom_range(0, 63)) << 2);
    if ($urandom_range(0, 3) == 0) pc[W-1] = 1'b1;
    return pc;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom};
  endfunction

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < NE; i++) mvalid[i] = 1'b0;
    for (int p = 0; p < NRD; p++) begin exp_hit[p] = 1'b0; exp_tgt[p] = '0; end
    exp_cnt = 0;
  endfunction

  // One edge of behaviour: drain first (so a same-edge write is visible), then look up, then enqueue.
  function automatic void model_step();
    bit           rdy, h;
    int           i;
    upd_t         u;
    logic [W-1:0] pc;
    rdy = (QD - mq.size()) >= NWR;
    if (inv_all) begin
      mq.delete();
      for (int k = 0; k < NE; k++) mvalid[k] = 1'b0;
      for (int p = 0; p < NRD; p++) begin exp_hit[p] = 1'b0; exp_tgt[p] = lk_npc[p*W +: W]; end
    end else begin
      if (mq.size() > 0) begin
        u = mq.pop_front();
        i = idx_of(u.pc);
        mvalid[i] = u.tkn;
        mtag[i]   = u.pc >> (IDXW + 2);
        mtgt[i]   = u.tgt;
      end
      for (int p = 0; p < NRD; p++) begin
        pc = lk_pc[p*W +: W];
        i  = idx_of(pc);
        h  = mvalid[i] && (mtag[i] == (pc >> (IDXW + 2)));
        exp_hit[p] = h;
        exp_tgt[p] = h ? mtgt[i] : lk_npc[p*W +: W];
      end
      if (rdy)
        for (int w = 0; w < NWR; w++)
          if (upd_wr[w]) mq.push_back('{pc: upd_pc[w*W +: W], tgt: upd_tgt[w*W +: W], tkn: upd_tkn[w]});
    end
    exp_cnt = mq.size();
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inv_all = 1'b0; upd_wr = '0; upd_tkn = '0; upd_pc = '0; upd_tgt = '0;
    lk_pc = '0; lk_npc = '0;
  endtask

  task automatic rand_lookups();
    for (int p = 0; p < NRD; p++) begin
      lk_pc[p*W +: W]  = (pool.size() > 0 && $urandom_range(0, 3) != 0) ?
                         pool[$urandom_range(0, pool.size() - 1)] : rnd_pc();
      lk_npc[p*W +: W] = rnd_w();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (lk_hit !== '0 || lk_tgt !== '0 || q_cnt !== '0 || upd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: hit=%b tgt=%h cnt=%0d rdy=%b, required 0/0/0/1", lk_hit, lk_tgt, q_cnt, upd_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int p = 0; p < NRD; p++) begin
      lk_pc[p*W +: W]  = 64'h1000;
      lk_npc[p*W +: W] = 64'h1004;
    end
    tick();
    for (int p = 0; p < NRD; p++) begin
      n_tests++;
      if (lk_hit[p] !== 1'b0 || lk_tgt[p*W +: W] !== 64'h1004) begin
        n_fail++;
        $display("FAIL reset_lookup p%0d: hit=%b tgt=%h, required 0/1004", p, lk_hit[p], lk_tgt[p*W +: W]);
      end
    end
    n_tests++;
    if (q_cnt !== '0 || upd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_queue: cnt=%0d rdy=%b, required 0/1", q_cnt, upd_rdy);
    end
  endtask

  task automatic test_bypass();
    clear_inputs();
    upd_wr[0] = 1'b1; upd_tkn[0] = 1'b1;
    upd_pc[0 +: W] = 64'h1000; upd_tgt[0 +: W] = 64'h2000;
    tick();
    clear_inputs();
    lk_pc[0 +: W] = 64'h1000;                      lk_npc[0 +: W] = 64'h1004;
    lk_pc[W +: W] = 64'h1000 + (64'd1 << (IDXW+2)); lk_npc[W +: W] = 64'h5004;
    tick();
    n_tests++;
    if (lk_hit[0] !== 1'b1 || lk_tgt[0 +: W] !== 64'h2000) begin
      n_fail++;
      $display("FAIL bypass_hit: hit=%b tgt=%h, required 1/2000", lk_hit[0], lk_tgt[0 +: W]);
    end
    n_tests++;
    if (lk_hit[1] !== 1'b0 || lk_tgt[W +: W] !== 64'h5004) begin
      n_fail++;
      $display("FAIL alias_miss: hit=%b tgt=%h, required 0/5004", lk_hit[1], lk_tgt[W +: W]);
    end
  endtask

  task automatic test_same_index();
    clear_inputs();
    for (int w = 0; w < NWR; w++) begin
      upd_wr[w] = 1'b1; upd_tkn[w] = 1'b1;
      upd_pc[w*W +: W]  = 64'h3000;
      upd_tgt[w*W +: W] = 64'hA0 + 64'(w) * 64'h10;
    end
    tick();
    clear_inputs();
    repeat (3) tick();
    lk_pc[0 +: W] = 64'h3000; lk_npc[0 +: W] = 64'h3004;
    tick();
    n_tests++;
    if (lk_hit[0] !== 1'b1 || lk_tgt[0 +: W] !== 64'hC0) begin
      n_fail++;
      $display("FAIL last_wins: hit=%b tgt=%h, required 1/c0", lk_hit[0], lk_tgt[0 +: W]);
    end
    upd_wr[0] = 1'b1; upd_tkn[0] = 1'b0; upd_pc[0 +: W] = 64'h3000; upd_tgt[0 +: W] = 64'hEE;
    tick();
    upd_wr = '0;
    repeat (2) tick();
    n_tests++;
    if (lk_hit[0] !== 1'b0 || lk_tgt[0 +: W] !== 64'h3004) begin
      n_fail++;
      $display("FAIL not_taken_inval: hit=%b tgt=%h, required 0/3004", lk_hit[0], lk_tgt[0 +: W]);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] pc;
    int guard;
    clear_inputs();
    for (int c = 0; c < 24; c++) begin
      for (int w = 0; w < NWR; w++) begin
        pc = rnd_pc();
        pool.push_back(pc);
        upd_wr[w] = 1'b1; upd_tkn[w] = ($urandom_range(0, 5) != 0);
        upd_pc[w*W +: W] = pc; upd_tgt[w*W +: W] = rnd_w();
      end
      n_tests++;
      if (upd_rdy !== ((QD - exp_cnt) >= NWR)) begin
        n_fail++;
        $display("FAIL fill_rdy c%0d: rdy=%b at cnt %0d", c, upd_rdy, exp_cnt);
      end
      tick();
      n_tests++;
      if (int'(q_cnt) !== exp_cnt || (c < 14 && int'(q_cnt) !== 2*c + 3)) begin
        n_fail++;
        $display("FAIL fill_cnt c%0d: cnt=%0d, required %0d", c, q_cnt, exp_cnt);
      end
    end
    clear_inputs();
    guard = 0;
    while (exp_cnt > 0 && guard < 40) begin
      rand_lookups();
      tick();
      guard++;
      for (int p = 0; p < NRD; p++) begin
        n_tests++;
        if (lk_hit[p] !== exp_hit[p] || lk_tgt[p*W +: W] !== exp_tgt[p]) begin
          n_fail++;
          $display("FAIL drain_lk p%0d: hit=%b tgt=%h, required %b/%h", p, lk_hit[p], lk_tgt[p*W +: W], exp_hit[p], exp_tgt[p]);
        end
      end
    end
    n_tests++;
    if (q_cnt !== '0 || guard >= 40) begin
      n_fail++;
      $display("FAIL drain_empty: cnt=%0d after %0d cycles, required 0", q_cnt, guard);
    end
  endtask

  task automatic test_inv_all();
    logic [W-1:0] pcx;
    int guard;
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      upd_wr[0] = 1'b1; upd_tkn[0] = 1'b1;
      upd_pc[0 +: W] = 64'(200 + k) << 2; upd_tgt[0 +: W] = 64'h5000 + 64'(k);
      tick();
    end
    clear_inputs();
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin lk_pc[k*W +: W] = 64'(200 + k) << 2; lk_npc[k*W +: W] = 64'h9000 + 64'(k); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (lk_hit[k] !== 1'b1 || lk_tgt[k*W +: W] !== 64'h5000 + 64'(k)) begin
        n_fail++;
        $display("FAIL inv_installed p%0d: hit=%b tgt=%h", k, lk_hit[k], lk_tgt[k*W +: W]);
      end
    end
    guard = 0;
    while (exp_cnt < 10 && guard < 10) begin
      for (int w = 0; w < NWR; w++) begin
        upd_wr[w] = 1'b1; upd_tkn[w] = 1'b1; upd_pc[w*W +: W] = rnd_pc(); upd_tgt[w*W +: W] = rnd_w();
      end
      tick();
      guard++;
    end
    n_tests++;
    if (int'(q_cnt) < 10) begin
      n_fail++;
      $display("FAIL inv_prefill: cnt=%0d, required >= 10", q_cnt);
    end
    pcx = 64'h7777_0000_0000_0640;
    inv_all = 1'b1;
    for (int w = 0; w < NWR; w++) begin upd_pc[w*W +: W] = pcx; upd_tgt[w*W +: W] = 64'hDEAD; end
    lk_pc[4*W +: W] = pcx; lk_npc[4*W +: W] = 64'hAAAA;
    lk_pc[5*W +: W] = pcx; lk_npc[5*W +: W] = 64'hBBBB;
    tick();
    inv_all = 1'b0; upd_wr = '0;
    n_tests++;
    if (q_cnt !== '0) begin
      n_fail++;
      $display("FAIL inv_cnt: cnt=%0d, required 0", q_cnt);
    end
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NRD; p++) begin
        n_tests++;
        if (lk_hit[p] !== 1'b0 || lk_tgt[p*W +: W] !== lk_npc[p*W +: W]) begin
          n_fail++;
          $display("FAIL inv_miss r%0d p%0d: hit=%b tgt=%h, required 0/%h", r, p, lk_hit[p], lk_tgt[p*W +: W], lk_npc[p*W +: W]);
        end
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    upd_wr[0] = 1'b1; upd_tkn[0] = 1'b1; upd_pc[0 +: W] = 64'h1000; upd_tgt[0 +: W] = 64'h2000;
    tick();
    for (int c = 0; c < 3; c++) begin
      for (int w = 0; w < NWR; w++) begin
        upd_wr[w] = 1'b1; upd_tkn[w] = 1'b1; upd_pc[w*W +: W] = rnd_pc(); upd_tgt[w*W +: W] = rnd_w();
      end
      lk_pc[0 +: W] = 64'h1000; lk_npc[0 +: W] = 64'h1004;
      tick();
    end
    n_tests++;
    if (int'(q_cnt) !== 7 || exp_cnt !== 7) begin
      n_fail++;
      $display("FAIL areset_pre: cnt=%0d, required 7", q_cnt);
    end
    clear_inputs();
    lk_pc[0 +: W] = 64'h1000; lk_npc[0 +: W] = 64'h1004;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (lk_hit !== '0 || lk_tgt !== '0 || q_cnt !== '0 || upd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_now: hit=%b cnt=%0d rdy=%b, required 0/0/1", lk_hit, q_cnt, upd_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      n_tests++;
      if (lk_hit !== '0 || lk_tgt[0 +: W] !== 64'h1004) begin
        n_fail++;
        $display("FAIL areset_miss r%0d: hit=%b tgt=%h, required 0/1004", r, lk_hit, lk_tgt[0 +: W]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pc;
    clear_inputs();
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < NWR; w++) begin
        pc = rnd_pc();
        pool.push_back(pc);
        upd_wr[w] = ($urandom_range(0, 2) != 0); upd_tkn[w] = ($urandom_range(0, 4) != 0);
        upd_pc[w*W +: W] = pc; upd_tgt[w*W +: W] = rnd_w();
      end
      inv_all = ($urandom_range(0, 59) == 0);
      rand_lookups();
      n_tests++;
      if (upd_rdy !== ((QD - exp_cnt) >= NWR)) begin
        n_fail++;
        $display("FAIL rand_rdy c%0d: rdy=%b at cnt %0d", c, upd_rdy, exp_cnt);
      end
      tick();
      n_tests++;
      if (int'(q_cnt) !== exp_cnt) begin
        n_fail++;
        $display("FAIL rand_cnt c%0d: cnt=%0d, required %0d", c, q_cnt, exp_cnt);
      end
      for (int p = 0; p < NRD; p++) begin
        n_tests++;
        if (lk_hit[p] !== exp_hit[p] || lk_tgt[p*W +: W] !== exp_tgt[p]) begin
          n_fail++;
          $display("FAIL rand_lk c%0d p%0d: hit=%b tgt=%h, required %b/%h", c, p, lk_hit[p], lk_tgt[p*W +: W], exp_hit[p], exp_tgt[p]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_same_index();
    test_fill();
    test_inv_all();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ft64_btb_mp.md
# ft64_btb_mp

Parametrised, single-clock branch target buffer for the FT64 fetch stage. It serves NRD parallel lookup ports, each returning a registered hit flag and target, with fall-through to the supplied next-PC on a miss. It accepts NWR branch-resolution updates per cycle into an in-order update queue with back-pressure, and drains one update per cycle into a direct-mapped table. The table has per-entry valid bits, asynchronous reset clear and a synchronous invalidate-all.

## Interface
- AMSB, 63, MSB of address/target fields (width W = AMSB+1)
- IDXW, 10, table index width; 2^IDXW entries; index = pc[IDXW+1:2]; tag = pc[AMSB:IDXW+2]
- NRD, 6, number of lookup ports
- NWR, 3, number of update ports (1..4)
- QLOG, 5, update queue depth QD = 2^QLOG; QD >= NWR required
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- inv_all  in  1  synchronous invalidate of all entries and queue
- upd_wr  in  NWR  per-port update strobe
- upd_pc  in  NWR*W  branch PC, port i at [i*W +: W]
- upd_tgt  in  NWR*W  branch target, port i at [i*W +: W]
- upd_tkn  in  NWR  1 = install/keep entry valid, 0 = invalidate entry
- upd_rdy  out  1  queue can absorb NWR entries this cycle
- lk_pc  in  NRD*W  lookup PC per port
- lk_npc  in  NRD*W  fall-through PC per port
- lk_hit  out  NRD  registered hit per port
- lk_tgt  out  NRD*W  registered predicted target per port
- q_cnt  out  QLOG+1  current queue occupancy

## Operation
- Table entry: valid, tag (W-IDXW-2 bits), target (W bits). Valid bits are flops, cleared by reset and inv_all. Tag/target are RAM-style, with no reset.
- Update enqueue: upd_rdy = (QD - q_cnt) >= NWR, combinational from q_cnt. At an edge with upd_rdy=1 and inv_all=0, every set upd_wr[i] is pushed in ascending port order, and entries are compacted (no gaps). Pushes offered while upd_rdy=0 are discarded with no state change; the producer holds them.
- Drain: each edge with q_cnt>0 and inv_all=0 pops the head and writes the table at index(pc): valid<=tkn, tag<=tag(pc), target<=tgt. Same-edge push and pop: q_cnt <= q_cnt + pushes - 1.
- Queue pointers wrap modulo QD. Updates to the same index apply in queue order, so the last update wins.
- Lookup: at each edge, for each port p, lk_hit[p] <= valid[idx] && tag[idx]==tag(lk_pc[p]). lk_tgt[p] <= hit ? target[idx] : lk_npc[p].
- Write-first bypass: if the drain writes idx at the same edge, the lookup uses the new valid/tag/target.
- inv_all: at the edge, all valid <= 0, queue emptied (q_cnt <= 0), and same-edge pushes and drain are discarded. Same-edge lookups register lk_hit=0, lk_tgt=lk_npc.
- Multiple lookup ports reading the same index are independent and identical; there are no port conflicts.

## Timing
- Reset (rst_n=0, async): valid[*]=0, head=tail=0, q_cnt=0, upd_rdy=1, lk_hit=0, lk_tgt=0. Release is synchronous to the next edge with no extra cycles.
- Reset mid-drain: queued updates are lost and the table becomes all-invalid.
- Lookup latency: 1 cycle. The PC sampled at edge L produces a result visible after L.
- Update-to-hit latency with an empty queue: push at edge E, table written at E+1. A lookup sampled at E+1 (bypass) hits.
- With k entries ahead in the queue, the write occurs at edge E+1+k.
- Full boundary: q_cnt = QD-NWR+1 forces upd_rdy=0. A drain lowers q_cnt at the next edge, and upd_rdy rises combinationally.
- Throughput: sustained drain rate is 1 update/cycle. NWR pushes per cycle are possible only while the queue has space.

## Test plan
- Reset then lookup pc=0x1000, npc=0x1004 on all ports -> lk_hit=0, lk_tgt=0x1004; q_cnt=0, upd_rdy=1.
- Push one update pc=0x1000, tgt=0x2000, tkn=1 at edge E; lookup 0x1000 sampled at E+1 -> lk_hit=1, lk_tgt=0x2000 (bypass). Aliased pc=0x1000+(1<<(IDXW+2)) -> miss, lk_tgt=npc.
- Same edge, ports 0/1/2 update index of 0x3000 with tgts 0xA0/0xB0/0xC0, all tkn=1 -> after 3 drains, lookup returns 0xC0. Then update with tkn=0 -> lk_hit=0.
- Hold all NWR strobes every cycle from empty -> q_cnt steps +2/cycle (3 in, 1 out) until upd_rdy=0 at q_cnt>=30 (QD=32). Held pushes are discarded, and every accepted update lands in order across the pointer wrap.
- Fill the queue with 10 entries and install 4 valid entries, then assert inv_all with a simultaneous push and lookup -> q_cnt=0, lookup miss, all later lookups miss, and the discarded push never appears.
- Assert rst_n=0 asynchronously between edges with q_cnt=7 -> outputs go to reset values immediately, and after release all lookups miss.
